// File: rtl/word_serializer_if.sv
// Handshake and serial-line bundle between an upstream word source and word_serializer.
interface word_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             out;
    logic             out_valid;
    logic             word_done;
    logic             busy;

    modport master (
        output din, din_valid,
        input  din_ready, out, out_valid, word_done, busy
    );

    modport slave (
        input  din, din_valid,
        output din_ready, out, out_valid, word_done, busy
    );
endinterface

// File: rtl/word_serializer.sv
// Parallel-to-serial stage: WIDTH-bit words in on valid/ready, one bit per clk out.
// Optional trailing even-parity bit when WORD_SERIALIZER_PARITY_EN is defined.
module word_serializer #(
    parameter int   WIDTH     = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    word_serializer_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
`ifdef WORD_SERIALIZER_PARITY_EN
    localparam int LAST_I = WIDTH;
`else
    localparam int LAST_I = WIDTH - 1;
`endif
    localparam logic [CW-1:0] LAST = CW'(LAST_I);

    typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] shreg_r, shreg_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic             out_r, out_s;
    logic             out_valid_r, out_valid_s;
    logic             word_done_r, word_done_s;
    logic             busy_r, busy_s;
    logic             din_ready_r, din_ready_s;
    logic             accept_s;
    logic             last_s;
`ifdef WORD_SERIALIZER_PARITY_EN
    logic             par_r, par_s;
`endif

    function automatic logic head_bit(input logic [WIDTH-1:0] s);
        return MSB_FIRST ? s[WIDTH-1] : s[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] s);
        return MSB_FIRST ? {s[WIDTH-2:0], 1'b0} : {1'b0, s[WIDTH-1:1]};
    endfunction

    function automatic logic even_parity(input logic [WIDTH-1:0] w);
        return ^w;
    endfunction

    assign accept_s = bus.din_valid && din_ready_r;
    assign last_s   = (state_r == SHIFT) && (cnt_r == LAST);

    // Next-state, datapath and next-output decode.
    always_comb begin
        state_s     = state_r;
        shreg_s     = shreg_r;
        cnt_s       = cnt_r;
`ifdef WORD_SERIALIZER_PARITY_EN
        par_s       = par_r;
`endif
        out_s       = IDLE_BIT;
        out_valid_s = 1'b0;
        word_done_s = 1'b0;
        busy_s      = 1'b0;
        din_ready_s = 1'b1;

        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = SHIFT;
                    shreg_s = bus.din;
                    cnt_s   = {CW{1'b0}};
`ifdef WORD_SERIALIZER_PARITY_EN
                    par_s   = even_parity(bus.din);
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (accept_s) begin
                    shreg_s = bus.din;
                    cnt_s   = {CW{1'b0}};
`ifdef WORD_SERIALIZER_PARITY_EN
                    par_s   = even_parity(bus.din);
`endif
                end else if (last_s) begin
                    state_s = IDLE;
                end else begin
                    shreg_s = shift_word(shreg_r);
                    cnt_s   = cnt_r + CW'(1);
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        if (state_s == SHIFT) begin
            busy_s      = 1'b1;
            out_valid_s = 1'b1;
            word_done_s = (cnt_s == LAST);
            din_ready_s = (cnt_s == LAST);
`ifdef WORD_SERIALIZER_PARITY_EN
            out_s       = (cnt_s == CW'(WIDTH)) ? par_s : head_bit(shreg_s);
`else
            out_s       = head_bit(shreg_s);
`endif
        end else begin
            din_ready_s = 1'b1;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            shreg_r     <= {WIDTH{1'b0}};
            cnt_r       <= {CW{1'b0}};
`ifdef WORD_SERIALIZER_PARITY_EN
            par_r       <= 1'b0;
`endif
            out_r       <= IDLE_BIT;
            out_valid_r <= 1'b0;
            word_done_r <= 1'b0;
            busy_r      <= 1'b0;
            din_ready_r <= 1'b1;
        end else begin
            state_r     <= state_s;
            shreg_r     <= shreg_s;
            cnt_r       <= cnt_s;
`ifdef WORD_SERIALIZER_PARITY_EN
            par_r       <= par_s;
`endif
            out_r       <= out_s;
            out_valid_r <= out_valid_s;
            word_done_r <= word_done_s;
            busy_r      <= busy_s;
            din_ready_r <= din_ready_s;
        end
    end

    assign bus.out       = out_r;
    assign bus.out_valid = out_valid_r;
    assign bus.word_done = word_done_r;
    assign bus.busy      = busy_r;
    assign bus.din_ready = din_ready_r;
endmodule

// File: tb/tb_word_serializer.sv
// Directed self-checking bench for word_serializer (MSB-first and LSB-first instances).
module tb_word_serializer;
`ifdef WORD_SERIALIZER_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    word_serializer_if #(.WIDTH(8)) bm ();
    word_serializer_if #(.WIDTH(8)) bl ();

    word_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) dut_msb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bm.slave)
    );

    word_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_lsb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bl.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " msb out"},   {7'd0, bm.out},       8'd1);
        check({tag, " msb valid"}, {7'd0, bm.out_valid}, 8'd0);
        check({tag, " msb ready"}, {7'd0, bm.din_ready}, 8'd1);
        check({tag, " msb busy"},  {7'd0, bm.busy},      8'd0);
        check({tag, " msb done"},  {7'd0, bm.word_done}, 8'd0);
        check({tag, " lsb out"},   {7'd0, bl.out},       8'd1);
        check({tag, " lsb valid"}, {7'd0, bl.out_valid}, 8'd0);
        check({tag, " lsb busy"},  {7'd0, bl.busy},      8'd0);
    endtask

    // Caller has already presented the word; this steps through its bits.
    task automatic stream(input string tag, input bit lsb, input logic [7:0] w,
                          input logic [7:0] next_din, input bit keep);
        logic [7:0] wv;
        logic       eb;
        wv = w;
        for (int i = 0; i < NB; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin
                if (lsb) begin
                    bl.din = next_din;
                    if (!keep) bl.din_valid = 1'b0;
                end else begin
                    bm.din = next_din;
                    if (!keep) bm.din_valid = 1'b0;
                end
            end
            if (i == 8) eb = ^wv;
            else        eb = lsb ? wv[i] : wv[7 - i];
            check($sformatf("%s bit%0d", tag, i), {7'd0, lsb ? bl.out : bm.out}, {7'd0, eb});
            check($sformatf("%s valid%0d", tag, i), {7'd0, lsb ? bl.out_valid : bm.out_valid}, 8'd1);
            check($sformatf("%s done%0d", tag, i), {7'd0, lsb ? bl.word_done : bm.word_done},
                  {7'd0, (i == NB - 1)});
            check($sformatf("%s ready%0d", tag, i), {7'd0, lsb ? bl.din_ready : bm.din_ready},
                  {7'd0, (i == NB - 1)});
            check($sformatf("%s busy%0d", tag, i), {7'd0, lsb ? bl.busy : bm.busy}, 8'd1);
        end
    endtask

    initial begin
        bm.din = 8'h00; bm.din_valid = 1'b0;
        bl.din = 8'h00; bl.din_valid = 1'b0;

        // Reset held for 3 cycles, then 10 idle cycles.
        repeat (3) @(posedge clk);
        #1;
        check("rst out",   {7'd0, bm.out},       8'd1);
        check("rst valid", {7'd0, bm.out_valid}, 8'd0);
        check("rst busy",  {7'd0, bm.busy},      8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check_idle("idle");
        end

        // Single MSB-first word A5.
        bm.din = 8'hA5; bm.din_valid = 1'b1;
        stream("a5", 1'b0, 8'hA5, 8'hA5, 1'b0);
        @(posedge clk); #1;
        check_idle("after a5");

        // LSB-first word 01; din changed to FF right after accept.
        bl.din = 8'h01; bl.din_valid = 1'b1;
        stream("lsb01", 1'b1, 8'h01, 8'hFF, 1'b0);
        @(posedge clk); #1;
        check_idle("after lsb01");

        // Back-to-back F0 then 0F with din_valid held high.
        bm.din = 8'hF0; bm.din_valid = 1'b1;
        stream("b2b f0", 1'b0, 8'hF0, 8'h0F, 1'b1);
        stream("b2b 0f", 1'b0, 8'h0F, 8'h0F, 1'b0);
        @(posedge clk); #1;
        check_idle("after b2b");

        // Reset in the middle of an FF word.
        bm.din = 8'hFF; bm.din_valid = 1'b1;
        @(posedge clk); #1;
        bm.din_valid = 1'b0;
        check("mid bit0", {7'd0, bm.out}, 8'd1);
        repeat (2) @(posedge clk);
        #1;
        check("mid bit2 valid", {7'd0, bm.out_valid}, 8'd1);
        rst_n = 1'b0;
        #1;
        check("mid rst out",   {7'd0, bm.out},       8'd1);
        check("mid rst valid", {7'd0, bm.out_valid}, 8'd0);
        check("mid rst busy",  {7'd0, bm.busy},      8'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_idle("after mid rst");
        bm.din = 8'h00; bm.din_valid = 1'b1;
        stream("post rst 00", 1'b0, 8'h00, 8'h00, 1'b0);
        @(posedge clk); #1;
        check_idle("after 00");

`ifdef WORD_SERIALIZER_PARITY_EN
        // Parity words: 07 gives parity 1, 03 gives parity 0.
        bm.din = 8'h07; bm.din_valid = 1'b1;
        stream("par07", 1'b0, 8'h07, 8'h07, 1'b0);
        @(posedge clk); #1;
        check_idle("after par07");
        bm.din = 8'h03; bm.din_valid = 1'b1;
        stream("par03", 1'b0, 8'h03, 8'h03, 1'b0);
        @(posedge clk); #1;
        check_idle("after par03");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/word_serializer.md
Name: word_serializer

Overview:
- Parallel-to-serial stage that feeds the 1-bit `in` input of the serial sequence detector/splitter stage.
- Accepts WIDTH-bit words on a valid/ready handshake and emits them one bit per clk on a single registered line.
- Holds the line at an idle level between words and supports gap-free back-to-back words.

Parameters:
- WIDTH, 8, data word width in bits; legal range is WIDTH >= 2.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
- IDLE_BIT, 1'b1, level driven on `out` while no word is being sent.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- din  input  WIDTH  word to serialize; sampled only on handshake.
- din_valid  input  1  upstream has a word on din.
- din_ready  output  1  block can accept a word this cycle.
- out  output  1  serial bit stream; drives the downstream stage's `in`.
- out_valid  output  1  `out` carries a data (or parity) bit this cycle.
- word_done  output  1  high during the cycle the final bit of a word is on `out`.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, shift register cleared, bit counter=0, out=IDLE_BIT, out_valid=0, word_done=0, busy=0, din_ready=1 once rst_n deasserts.
- Handshake: a word is accepted on a rising edge where din_valid && din_ready. din is captured into the shift register at that edge. din and din_valid are ignored at all other times.
- States:
  - IDLE: out=IDLE_BIT, out_valid=0, din_ready=1. On accept go to SHIFT, counter=0.
  - SHIFT: out = current head bit of the shift register, out_valid=1. Each edge shifts by one and counter increments.
  - After the bit at counter==WIDTH-1: on accept, reload and stay in SHIFT with counter=0. With no accept, return to IDLE.
- Latency: the first bit appears on `out` in the cycle after the accepting edge. A word occupies exactly WIDTH consecutive cycles (WIDTH+1 with parity).
- din_ready = IDLE || (SHIFT && last bit of word on `out`). This allows back-to-back words with zero idle cycles between them.
- word_done = SHIFT && last bit on `out`. It is a one-cycle pulse per word.
- Bit order: MSB_FIRST=1 sends din[WIDTH-1] down to din[0]; MSB_FIRST=0 sends din[0] up to din[WIDTH-1].
- Counter width is $clog2(WIDTH+1). There is no wrap beyond the word length; the counter resets to 0 on every reload.
- All outputs are registered or decoded directly from registered state. There is no combinational path from din/din_valid to any output except none (din_ready depends only on state).
- Reset mid-word: the word in flight is discarded without completion. out returns immediately to IDLE_BIT and out_valid drops asynchronously.
- din_valid held high with a constant din: the same word is re-accepted and streamed continuously.

Optional Feature:
- Macro: WORD_SERIALIZER_PARITY_EN.
- Defined: after the last data bit, one extra SHIFT cycle carries even parity, the XOR of the captured word. out_valid=1 during that cycle, and word_done and din_ready move to the parity cycle. A word takes WIDTH+1 cycles.
- Undefined: no parity cycle, and the behaviour is exactly as described above.

Test Plan:
- Reset then idle: hold rst_n=0 for 3 cycles, release, din_valid=0 for 10 cycles -> out=1, out_valid=0, din_ready=1, busy=0 throughout.
- Single word, MSB_FIRST=1: accept din=8'hA5 -> next 8 cycles out=1,0,1,0,0,1,0,1 with out_valid=1, word_done high only in cycle 8, then out=1 idle.
- LSB-first: MSB_FIRST=0, din=8'h01 -> out=1,0,0,0,0,0,0,0. Changing din to 8'hFF mid-word has no effect on the stream.
- Back-to-back: din_valid held high with 8'hF0 then 8'h0F -> 16 contiguous valid bits 11110000 00001111, no idle gap, two word_done pulses 8 cycles apart.
- Reset mid-word: accept 8'hFF, pull rst_n low after 3 bits -> out=1 and out_valid=0 immediately. After release, the next accepted word 8'h00 streams complete and correct.
- Parity (macro defined): 8'h07 -> 00000111 then parity bit 1, word_done on the 9th bit. 8'h03 gives parity bit 0.
